// File: rtl/pmem_rr_arbiter_if.sv
// Cache-side and memory-side bus of the shared physical-memory port.
// The arbiter takes the slave view; the requesters plus memory take master.
interface pmem_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              pmem_read_c_i;
  logic              pmem_write_c_i;
  logic [ADDR_W-1:0] pmem_address_c_i;
  logic [LINE_W-1:0] pmem_wdata_c_i;
  logic              pmem_resp_c_i;
  logic [LINE_W-1:0] pmem_rdata_c_i;
  logic              pmem_read_c_d;
  logic              pmem_write_c_d;
  logic [ADDR_W-1:0] pmem_address_c_d;
  logic [LINE_W-1:0] pmem_wdata_c_d;
  logic              pmem_resp_c_d;
  logic [LINE_W-1:0] pmem_rdata_c_d;
  logic              pmem_read_m;
  logic              pmem_write_m;
  logic [ADDR_W-1:0] pmem_address_m;
  logic [LINE_W-1:0] pmem_wdata_m;
  logic              pmem_resp_m;
  logic [LINE_W-1:0] pmem_rdata_m;

  modport slave (
    input  pmem_read_c_i, pmem_write_c_i,
    input  pmem_address_c_i, pmem_wdata_c_i,
    output pmem_resp_c_i, pmem_rdata_c_i,
    input  pmem_read_c_d, pmem_write_c_d,
    input  pmem_address_c_d, pmem_wdata_c_d,
    output pmem_resp_c_d, pmem_rdata_c_d,
    output pmem_read_m, pmem_write_m,
    output pmem_address_m, pmem_wdata_m,
    input  pmem_resp_m, pmem_rdata_m
  );

  modport master (
    output pmem_read_c_i, pmem_write_c_i,
    output pmem_address_c_i, pmem_wdata_c_i,
    input  pmem_resp_c_i, pmem_rdata_c_i,
    output pmem_read_c_d, pmem_write_c_d,
    output pmem_address_c_d, pmem_wdata_c_d,
    input  pmem_resp_c_d, pmem_rdata_c_d,
    input  pmem_read_m, pmem_write_m,
    input  pmem_address_m, pmem_wdata_m,
    output pmem_resp_m, pmem_rdata_m
  );
endinterface

// File: rtl/pmem_rr_arbiter.sv
// Registered I/D-cache arbiter for one physical-memory port, with
// round-robin or D-priority tie-break and a sticky hang watchdog.
module pmem_rr_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_rr_arbiter_if.slave bus,
  output logic             busy,
  output logic             timeout_err
);
  typedef enum logic [1:0] {
    IDLE, GRANT_I, GRANT_D
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_d;
  logic              r_read_m;
  logic              r_write_m;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [15:0]       r_wd;
  logic              r_err;
  logic [15:0]       w_wd_inc;
  logic              w_req_i;
  logic              w_req_d;
  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_busy;
  logic              w_hang;
  logic              w_resp_i;
  logic              w_resp_d;

  assign w_req_i = bus.pmem_read_c_i | bus.pmem_write_c_i;
  assign w_req_d = bus.pmem_read_c_d | bus.pmem_write_c_d;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    case (r_state)
      IDLE: begin
        unique case (1'b1)
          (w_req_i && !w_req_d): w_gnt_i = 1'b1;
          (!w_req_i && w_req_d): w_gnt_d = 1'b1;
          (w_req_i && w_req_d): begin
            // RR hands a tie to whoever did not win last
            if (RR_MODE != 0 && r_last_d)
              w_gnt_i = 1'b1;
            else
              w_gnt_d = 1'b1;
          end
          default: ;
        endcase
        if (w_gnt_i)
          w_state_nxt = GRANT_I;
        else if (w_gnt_d)
          w_state_nxt = GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        if (bus.pmem_resp_m)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_read_m  <= 1'b0;
      r_write_m <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_i || w_gnt_d) begin
        r_last_d <= w_gnt_d;
        if (w_gnt_d) begin
          r_addr    <= bus.pmem_address_c_d;
          r_wdata   <= bus.pmem_wdata_c_d;
          r_write_m <= bus.pmem_write_c_d;
          r_read_m  <= bus.pmem_read_c_d & ~bus.pmem_write_c_d;
        end else begin
          r_addr    <= bus.pmem_address_c_i;
          r_wdata   <= bus.pmem_wdata_c_i;
          r_write_m <= bus.pmem_write_c_i;
          r_read_m  <= bus.pmem_read_c_i & ~bus.pmem_write_c_i;
        end
      end else if (w_busy && bus.pmem_resp_m) begin
        r_read_m  <= 1'b0;
        r_write_m <= 1'b0;
      end
    end
  end

  assign w_busy   = (r_state != IDLE);
  assign w_hang   = w_busy && !bus.pmem_resp_m;
  assign w_wd_inc = (r_wd == 16'hFFFF) ? r_wd : r_wd + 16'd1;

  // Watchdog only flags; the transaction keeps waiting on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd <= w_hang ? w_wd_inc : 16'd0;
      if (w_hang && TIMEOUT_CYC != 0 && w_wd_inc >= TO_LIM)
        r_err <= 1'b1;
    end
  end

  assign w_resp_i = (r_state == GRANT_I) && bus.pmem_resp_m;
  assign w_resp_d = (r_state == GRANT_D) && bus.pmem_resp_m;

  assign bus.pmem_resp_c_i  = w_resp_i;
  assign bus.pmem_resp_c_d  = w_resp_d;
  assign bus.pmem_rdata_c_i = w_resp_i ? bus.pmem_rdata_m : '0;
  assign bus.pmem_rdata_c_d = w_resp_d ? bus.pmem_rdata_m : '0;

  assign bus.pmem_read_m    = r_read_m;
  assign bus.pmem_write_m   = r_write_m;
  assign bus.pmem_address_m = r_addr;
  assign bus.pmem_wdata_m   = r_wdata;

  assign busy        = w_busy;
  assign timeout_err = r_err;
endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Bench for pmem_rr_arbiter: RR/timeout instance plus a D-priority one,
// vector table for single grants, scoreboard for cache responses.
module tb_pmem_rr_arbiter;
  localparam logic [255:0] P_11 = {32{8'h11}};
  localparam logic [255:0] P_22 = {32{8'h22}};
  localparam logic [255:0] P_33 = {32{8'h33}};
  localparam logic [255:0] P_44 = {32{8'h44}};
  localparam logic [255:0] P_A5 = {32{8'hA5}};
  localparam logic [255:0] P_5A = {32{8'h5A}};

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic         rd_i, wr_i, rd_d, wr_d;
  logic [31:0]  a_i, a_d;
  logic [255:0] wd_i, wd_d;
  logic         resp_m;
  logic [255:0] rdata_m;

  logic         busy0, busy1, err0, err1;
  logic         o_read_m, o_write_m, o_resp_i, o_resp_d;
  logic         o_busy, o_err;
  logic [31:0]  o_addr_m;
  logic [255:0] o_wdata_m, o_rdata_i, o_rdata_d;

  int n_chk;
  int n_fail;

  typedef struct {
    logic         d;
    logic [255:0] data;
  } sb_t;
  sb_t sb[$];

  pmem_rr_arbiter_if #(.ADDR_W(32), .LINE_W(256)) if0 ();
  pmem_rr_arbiter_if #(.ADDR_W(32), .LINE_W(256)) if1 ();

  pmem_rr_arbiter #(
    .ADDR_W(32), .LINE_W(256), .RR_MODE(1), .TIMEOUT_CYC(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .busy(busy0), .timeout_err(err0)
  );

  pmem_rr_arbiter #(
    .ADDR_W(32), .LINE_W(256), .RR_MODE(0), .TIMEOUT_CYC(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .busy(busy1), .timeout_err(err1)
  );

  assign if0.pmem_read_c_i    = ~sel & rd_i;
  assign if0.pmem_write_c_i   = ~sel & wr_i;
  assign if0.pmem_address_c_i = a_i;
  assign if0.pmem_wdata_c_i   = wd_i;
  assign if0.pmem_read_c_d    = ~sel & rd_d;
  assign if0.pmem_write_c_d   = ~sel & wr_d;
  assign if0.pmem_address_c_d = a_d;
  assign if0.pmem_wdata_c_d   = wd_d;
  assign if0.pmem_resp_m      = ~sel & resp_m;
  assign if0.pmem_rdata_m     = sel ? '0 : rdata_m;

  assign if1.pmem_read_c_i    = sel & rd_i;
  assign if1.pmem_write_c_i   = sel & wr_i;
  assign if1.pmem_address_c_i = a_i;
  assign if1.pmem_wdata_c_i   = wd_i;
  assign if1.pmem_read_c_d    = sel & rd_d;
  assign if1.pmem_write_c_d   = sel & wr_d;
  assign if1.pmem_address_c_d = a_d;
  assign if1.pmem_wdata_c_d   = wd_d;
  assign if1.pmem_resp_m      = sel & resp_m;
  assign if1.pmem_rdata_m     = sel ? rdata_m : '0;

  assign o_read_m  = sel ? if1.pmem_read_m    : if0.pmem_read_m;
  assign o_write_m = sel ? if1.pmem_write_m   : if0.pmem_write_m;
  assign o_addr_m  = sel ? if1.pmem_address_m : if0.pmem_address_m;
  assign o_wdata_m = sel ? if1.pmem_wdata_m   : if0.pmem_wdata_m;
  assign o_resp_i  = sel ? if1.pmem_resp_c_i  : if0.pmem_resp_c_i;
  assign o_resp_d  = sel ? if1.pmem_resp_c_d  : if0.pmem_resp_c_d;
  assign o_rdata_i = sel ? if1.pmem_rdata_c_i : if0.pmem_rdata_c_i;
  assign o_rdata_d = sel ? if1.pmem_rdata_c_d : if0.pmem_rdata_c_d;
  assign o_busy    = sel ? busy1 : busy0;
  assign o_err     = sel ? err1  : err0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk1(string nm, logic a, logic e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", nm, a, e);
    end
  endfunction

  function automatic void chkw(string nm, logic [255:0] a,
                               logic [255:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic void push_exp(logic d, logic [255:0] x);
    sb_t e;
    e.d    = d;
    e.data = x;
    sb.push_back(e);
  endfunction

  // Scoreboard side: every cache response must match a pushed entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_resp_i || o_resp_d) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got resp_i=%0b resp_d=%0b, expected none",
                   o_resp_i, o_resp_d);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk1("sb_resp_i", o_resp_i, ~e.d);
          chk1("sb_resp_d", o_resp_d, e.d);
          chkw("sb_rdata", e.d ? o_rdata_d : o_rdata_i, e.data);
          chkw("sb_other_rdata", e.d ? o_rdata_i : o_rdata_d, '0);
        end
      end else begin
        chkw("rdata_no_resp", o_rdata_i | o_rdata_d, '0);
      end
    end
  end

  typedef struct {
    logic         s;
    logic [1:0]   oi, od;
    logic [31:0]  ai, ad;
    logic [255:0] wi, wdd;
    int           lat;
    logic         scr;
    logic         ed, erd, ewr;
    logic [31:0]  ea;
    logic [255:0] ew;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(
    logic s, logic [1:0] oi, logic [1:0] od,
    logic [31:0] ai, logic [31:0] ad,
    logic [255:0] wi, logic [255:0] wdd,
    int lat, logic scr, logic ed, logic erd, logic ewr,
    logic [31:0] ea, logic [255:0] ew);
    vec_t v;
    v.s = s; v.oi = oi; v.od = od; v.ai = ai; v.ad = ad;
    v.wi = wi; v.wdd = wdd; v.lat = lat; v.scr = scr;
    v.ed = ed; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ew = ew;
    return v;
  endfunction

  task automatic drop();
    rd_i = 1'b0; wr_i = 1'b0; rd_d = 1'b0; wr_d = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    rst_n = 1'b0;
    drop();
    resp_m = 1'b0;
    rdata_m = '0;
    @(posedge clk); #1;
    if (check) begin
      for (int s = 0; s < 2; s++) begin
        sel = s[0];
        #1;
        chk1("rst_read_m", o_read_m, 1'b0);
        chk1("rst_write_m", o_write_m, 1'b0);
        chkw("rst_addr_m", 256'(o_addr_m), '0);
        chkw("rst_wdata_m", o_wdata_m, '0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_err", o_err, 1'b0);
      end
    end
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Requests are already driven; grant, optional stall, then mem resp
  task automatic run_txn(input logic ed, input logic erd,
                         input logic ewr, input logic [31:0] ea,
                         input logic [255:0] ew, input int lat,
                         input logic scr, input logic [255:0] rd);
    @(posedge clk); #1;
    chk1("read_m", o_read_m, erd);
    chk1("write_m", o_write_m, ewr);
    chkw("addr_m", 256'(o_addr_m), 256'(ea));
    chkw("wdata_m", o_wdata_m, ew);
    chk1("busy", o_busy, 1'b1);
    for (int k = 1; k < lat; k++) begin
      if (scr) begin
        a_d = ~a_d; wd_d = ~wd_d; rd_d = ~rd_d; a_i = ~a_i;
      end
      @(posedge clk); #1;
    end
    if (scr) begin
      chkw("hold_addr_m", 256'(o_addr_m), 256'(ea));
      chkw("hold_wdata_m", o_wdata_m, ew);
      chk1("hold_read_m", o_read_m, erd);
      chk1("hold_write_m", o_write_m, ewr);
    end
    resp_m = 1'b1;
    rdata_m = rd;
    push_exp(ed, rd);
    @(posedge clk); #1;
    resp_m = 1'b0;
    rdata_m = '0;
    chk1("end_read_m", o_read_m, 1'b0);
    chk1("end_write_m", o_write_m, 1'b0);
    chk1("end_busy", o_busy, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    a_i = '0; a_d = '0; wd_i = '0; wd_d = '0;
    drop();
    resp_m = 1'b0;
    rdata_m = '0;

    // dut0 starts with last grant = D, dut1 is fixed D priority
    vt[0] = mk(0, 2'b01, 2'b00, 32'h0000_1000, 32'h0, P_11, '0,
               5, 0, 0, 1, 0, 32'h0000_1000, P_11);
    vt[1] = mk(0, 2'b00, 2'b10, 32'h0, 32'h8000_0040, '0, P_A5,
               4, 1, 1, 0, 1, 32'h8000_0040, P_A5);
    vt[2] = mk(0, 2'b01, 2'b01, 32'h2000, 32'h3000, P_22, P_33,
               2, 0, 0, 1, 0, 32'h2000, P_22);
    vt[3] = mk(0, 2'b10, 2'b01, 32'h2040, 32'h3040, P_44, P_33,
               1, 0, 1, 1, 0, 32'h3040, P_33);
    vt[4] = mk(0, 2'b00, 2'b11, 32'h0, 32'h4000, '0, P_5A,
               3, 0, 1, 0, 1, 32'h4000, P_5A);
    vt[5] = mk(0, 2'b11, 2'b00, 32'h5000, 32'h0, P_11, '0,
               2, 0, 0, 0, 1, 32'h5000, P_11);
    vt[6] = mk(0, 2'b01, 2'b10, 32'h6000, 32'h7000, P_22, P_44,
               2, 0, 1, 0, 1, 32'h7000, P_44);
    vt[7] = mk(1, 2'b01, 2'b01, 32'h0100, 32'h0200, P_11, P_22,
               2, 0, 1, 1, 0, 32'h0200, P_22);
    vt[8] = mk(1, 2'b10, 2'b01, 32'h0400, 32'h0500, P_44, P_5A,
               3, 0, 1, 1, 0, 32'h0500, P_5A);
    vt[9] = mk(1, 2'b01, 2'b00, 32'h0300, 32'h0, P_33, '0,
               2, 0, 0, 1, 0, 32'h0300, P_33);

    do_reset(1'b1);

    for (int i = 0; i < 10; i++) begin
      sel = vt[i].s;
      {wr_i, rd_i} = vt[i].oi;
      {wr_d, rd_d} = vt[i].od;
      a_i = vt[i].ai; a_d = vt[i].ad;
      wd_i = vt[i].wi; wd_d = vt[i].wdd;
      run_txn(vt[i].ed, vt[i].erd, vt[i].ewr, vt[i].ea,
              vt[i].ew, vt[i].lat, vt[i].scr, rand256());
      drop();
    end

    // memory response while idle must go nowhere
    sel = 1'b0;
    resp_m = 1'b1;
    rdata_m = P_A5;
    @(posedge clk); #1;
    resp_m = 1'b0;
    rdata_m = '0;
    chk1("idle_resp_busy", o_busy, 1'b0);
    chk1("idle_resp_read_m", o_read_m, 1'b0);
    rd_d = 1'b1; a_d = 32'h0000_9000; wd_d = P_33;
    run_txn(1, 1, 0, 32'h0000_9000, P_33, 2, 0, rand256());
    drop();

    // continuous contention, round robin
    do_reset(1'b0);
    rd_i = 1'b1; rd_d = 1'b1;
    a_i = 32'h0000_A000; a_d = 32'h0000_B000;
    wd_i = P_11; wd_d = P_22;
    for (int k = 0; k < 4; k++) begin
      logic dd;
      dd = (k % 2) == 1;
      run_txn(dd, 1, 0, dd ? 32'h0000_B000 : 32'h0000_A000,
              dd ? P_22 : P_11, 3, 0, rand256());
    end
    drop();

    // continuous contention, D priority
    sel = 1'b1;
    rd_i = 1'b1; rd_d = 1'b1;
    for (int k = 0; k < 3; k++)
      run_txn(1, 1, 0, 32'h0000_B000, P_22, 2, 0, rand256());
    drop();
    chk1("dprio_no_err", o_err, 1'b0);
    sel = 1'b0;

    // watchdog at 8 stalled grant cycles, sticky past late response
    rd_i = 1'b1; a_i = 32'h0000_C000; wd_i = P_44;
    @(posedge clk); #1;
    chk1("to_read_m", o_read_m, 1'b1);
    chk1("to_err_start", o_err, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk1("to_err_7", o_err, 1'b0);
    @(posedge clk); #1;
    chk1("to_err_8", o_err, 1'b1);
    chk1("to_busy", o_busy, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chkw("to_addr_held", 256'(o_addr_m), 256'(32'h0000_C000));
    rdata_m = rand256();
    resp_m = 1'b1;
    push_exp(1'b0, rdata_m);
    @(posedge clk); #1;
    resp_m = 1'b0;
    rdata_m = '0;
    rd_i = 1'b0;
    chk1("to_late_busy", o_busy, 1'b0);
    chk1("to_sticky", o_err, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk1("to_sticky2", o_err, 1'b1);

    // asynchronous reset in the middle of a grant
    rd_d = 1'b1; a_d = 32'h0000_D000;
    @(posedge clk); #1;
    chk1("mr_read_m", o_read_m, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mr_read_m_async", o_read_m, 1'b0);
    chk1("mr_busy_async", o_busy, 1'b0);
    chk1("mr_err_async", o_err, 1'b0);
    drop();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    chk1("sb_drained", sb.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
